// File: rtl/systolic_array.sv
// Output-stationary NxN systolic array for C = A*B over MxM matrices.
// Generates A/B operand read addresses and emits one NxN tile per sweep.
module systolic_array #(
  parameter int D_W = 8,
  parameter int D_W_ACC = 16,
  parameter int N = 3,
  parameter int M = 6,
  localparam int NS = M / N,
  localparam int SW = (NS > 1) ? $clog2(NS) : 1,
  localparam int KW = (M > 1) ? $clog2(M) : 1,
  localparam int AW = (M * NS > 1) ? $clog2(M * NS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_row_count_A,
  output logic [SW-1:0]      slice_cntr_A,
  output logic [KW-1:0]      pixel_cntr_A,
  output logic [KW-1:0]      slice_cntr_B,
  output logic [SW-1:0]      pixel_cntr_B,
  output logic [AW-1:0]      rd_addr_A,
  output logic [AW-1:0]      rd_addr_B,
  input  logic [D_W-1:0]     A [N],
  input  logic [D_W-1:0]     B [N],
  output logic [D_W_ACC-1:0] D [N][N],
  output logic               valid_D [N][N]
);

  logic a_wrap;
  logic b_wrap;
  logic start;

  logic [2*N-2:0] init_sr;

  logic [D_W-1:0] a_q [N][N];
  logic [D_W-1:0] b_q [N][N];

  assign a_wrap = (pixel_cntr_A == KW'(M - 1));
  assign b_wrap = (slice_cntr_B == KW'(M - 1));
  assign start  = (pixel_cntr_A == '0) && !rst;

  assign rd_addr_A = AW'(int'(slice_cntr_A) * M + int'(pixel_cntr_A));
  assign rd_addr_B = AW'(int'(pixel_cntr_B) * M + int'(slice_cntr_B));

  // Free-running sweep counters; A row-slice advances only when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_cntr_A <= '0;
      slice_cntr_A <= '0;
      slice_cntr_B <= '0;
      pixel_cntr_B <= '0;
    end else begin
      pixel_cntr_A <= a_wrap ? '0 : pixel_cntr_A + 1'b1;
      slice_cntr_B <= b_wrap ? '0 : slice_cntr_B + 1'b1;
      if (b_wrap) begin
        if (pixel_cntr_B == SW'(NS - 1))
          pixel_cntr_B <= '0;
        else
          pixel_cntr_B <= pixel_cntr_B + 1'b1;
      end
      if (a_wrap && enable_row_count_A) begin
        if (slice_cntr_A == SW'(NS - 1))
          slice_cntr_A <= '0;
        else
          slice_cntr_A <= slice_cntr_A + 1'b1;
      end
    end
  end

  // Shared start delay line; PE[x][y] taps stage x+y (x+y+1 cycles late).
  always_ff @(posedge clk) begin
    if (rst) begin
      init_sr <= '0;
    end else begin
      init_sr[0] <= start;
      for (int d = 1; d < 2 * N - 1; d++)
        init_sr[d] <= init_sr[d-1];
    end
  end

  for (genvar gx = 0; gx < N; gx++) begin : g_row
    for (genvar gy = 0; gy < N; gy++) begin : g_col
      logic [D_W-1:0]     a_in;
      logic [D_W-1:0]     b_in;
      logic [D_W-1:0]     a_r;
      logic [D_W-1:0]     b_r;
      logic [2*D_W-1:0]   prod;
      logic [D_W_ACC-1:0] prod_w;
      logic [D_W_ACC-1:0] acc;
      logic [D_W_ACC-1:0] d_r;
      logic               init;
      logic               seen;
      logic               v_r;

      if (gy == 0) begin : g_a0
        assign a_in = A[gx];
      end else begin : g_an
        assign a_in = a_q[gx][gy-1];
      end

      if (gx == 0) begin : g_b0
        assign b_in = B[gy];
      end else begin : g_bn
        assign b_in = b_q[gx-1][gy];
      end

      assign init   = init_sr[gx+gy];
      assign prod   = {{D_W{1'b0}}, a_in} * {{D_W{1'b0}}, b_in};
      assign prod_w = D_W_ACC'(prod);

      // Forward operands; on init dump the finished sum and restart it.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_r  <= '0;
          b_r  <= '0;
          acc  <= '0;
          d_r  <= '0;
          v_r  <= 1'b0;
          seen <= 1'b0;
        end else begin
          a_r <= a_in;
          b_r <= b_in;
          if (init) begin
            d_r  <= acc;
            v_r  <= seen;
            acc  <= prod_w;
            seen <= 1'b1;
          end else begin
            acc <= acc + prod_w;
            v_r <= 1'b0;
          end
        end
      end

      assign a_q[gx][gy]     = a_r;
      assign b_q[gx][gy]     = b_r;
      assign D[gx][gy]       = d_r;
      assign valid_D[gx][gy] = v_r;
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: models the skewing wrapper and
// checks addresses, tile results, strobe timing and reset behaviour.
module tb_systolic_array;

  localparam int D_W = 8;
  localparam int D_W_ACC = 16;
  localparam int N = 3;
  localparam int M = 6;
  localparam int NS = M / N;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [0:0]         slice_cntr_A;
  logic [2:0]         pixel_cntr_A;
  logic [2:0]         slice_cntr_B;
  logic [0:0]         pixel_cntr_B;
  logic [3:0]         rd_addr_A;
  logic [3:0]         rd_addr_B;
  logic [D_W-1:0]     a_lane [N];
  logic [D_W-1:0]     b_lane [N];
  logic [D_W_ACC-1:0] d_out [N][N];
  logic               v_out [N][N];

  int checks = 0;
  int errors = 0;
  int cyc;
  int pat;
  int first00;
  int last00;
  int tcnt [N][N];
  int ha [N+1][N];
  int hb [N+1][N];

  systolic_array #(
    .D_W(D_W), .D_W_ACC(D_W_ACC), .N(N), .M(M)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable_row_count_A(en),
    .slice_cntr_A(slice_cntr_A),
    .pixel_cntr_A(pixel_cntr_A),
    .slice_cntr_B(slice_cntr_B),
    .pixel_cntr_B(pixel_cntr_B),
    .rd_addr_A(rd_addr_A),
    .rd_addr_B(rd_addr_B),
    .A(a_lane),
    .B(b_lane),
    .D(d_out),
    .valid_D(v_out)
  );

  always #5 clk = ~clk;

  // patterns: 0 identity, 1 all ones, 2 rows r+1 / B=2, 3 all 0xFF
  function automatic int mat_a(int p, int r, int c);
    case (p)
      0: return (r == c) ? 1 : 0;
      1: return 1;
      2: return r + 1;
      default: return 255;
    endcase
  endfunction

  function automatic int mat_b(int p, int r, int c);
    case (p)
      0: return (r == c) ? 1 : 0;
      1: return 1;
      2: return 2;
      default: return 255;
    endcase
  endfunction

  // hand-derived C[r][c]; 0xFF case is 6*65025 mod 65536
  function automatic int exp_c(int p, int r, int c);
    case (p)
      0: return (r == c) ? 1 : 0;
      1: return 6;
      2: return 12 * (r + 1);
      default: return 62470;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    int ai, ak, bj, bk;
    en = (cyc % M == M - 1) && ((cyc / M) % NS == NS - 1);
    for (int h = N; h > 0; h--)
      for (int x = 0; x < N; x++) begin
        ha[h][x] = ha[h-1][x];
        hb[h][x] = hb[h-1][x];
      end
    ai = int'(rd_addr_A) / M;
    ak = int'(rd_addr_A) % M;
    bj = int'(rd_addr_B) / M;
    bk = int'(rd_addr_B) % M;
    for (int x = 0; x < N; x++) begin
      ha[0][x] = mat_a(pat, ai * N + x, ak);
      hb[0][x] = mat_b(pat, bk, bj * N + x);
    end
    for (int x = 0; x < N; x++) begin
      a_lane[x] = D_W'(ha[x+1][x]);
      b_lane[x] = D_W'(hb[x+1][x]);
    end
  endtask

  task automatic monitor();
    int t, r, c, ea, eb;
    ea = ((cyc / (M * NS)) % NS) * M + cyc % M;
    eb = ((cyc / M) % NS) * M + cyc % M;
    check($sformatf("addrA_c%0d", cyc), rd_addr_A, ea);
    check($sformatf("addrB_c%0d", cyc), rd_addr_B, eb);
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++)
        if (v_out[x][y]) begin
          t = tcnt[x][y] % (NS * NS);
          r = (t / NS) * N + x;
          c = (t % NS) * N + y;
          check($sformatf("p%0d_D%0d%0d_t%0d", pat, x, y, t),
                d_out[x][y], exp_c(pat, r, c));
          tcnt[x][y]++;
          if (x == 0 && y == 0) begin
            if (first00 < 0) first00 = cyc;
            last00 = cyc;
          end else begin
            check($sformatf("skew%0d%0d", x, y), cyc - last00, x + y);
          end
        end
  endtask

  task automatic run_test(input int p, input int ncyc, input bit full);
    int vs;
    pat = p;
    rst = 1'b1;
    en = 1'b0;
    @(posedge clk);
    #1;
    check("rst_addrA", rd_addr_A, 0);
    check("rst_addrB", rd_addr_B, 0);
    check("rst_cnt",
          {slice_cntr_A, pixel_cntr_A, slice_cntr_B, pixel_cntr_B}, 0);
    vs = 0;
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++) begin
        vs += int'(v_out[x][y]);
        check($sformatf("rst_D%0d%0d", x, y), d_out[x][y], 0);
      end
    check("rst_valid", vs, 0);
    rst = 1'b0;
    first00 = -1;
    last00 = -1;
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++)
        tcnt[x][y] = 0;
    for (int n = 0; n < ncyc; n++) begin
      cyc = n;
      monitor();
      drive();
      @(posedge clk);
      #1;
    end
    if (full) begin
      check($sformatf("p%0d_first00", p), first00, 8);
      check($sformatf("p%0d_cnt22", p), tcnt[N-1][N-1], NS * NS);
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    for (int x = 0; x < N; x++) begin
      a_lane[x] = '0;
      b_lane[x] = '0;
    end
    for (int h = 0; h <= N; h++)
      for (int x = 0; x < N; x++) begin
        ha[h][x] = 0;
        hb[h][x] = 0;
      end
    run_test(0, 36, 1'b1);
    run_test(1, 36, 1'b1);
    run_test(3, 36, 1'b1);
    run_test(1, 15, 1'b0);
    run_test(2, 36, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
